// File: rtl/sa_cache_refill_ctrl.sv
// Miss sequencer between the set-associative cache and the word-wide memory bus.
// Optional per-beat ack watchdog enabled by defining SA_REFILL_TIMEOUT_EN.
module sa_cache_refill_ctrl #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cache_miss,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  input  logic                         i_evict,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_line,
  input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
  output logic [LINE_SIZE_BYTES*8-1:0] o_fill_line,
  output logic                         o_fill_valid,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int LINE_W         = LINE_SIZE_BYTES * 8;
  localparam int BEATS          = LINE_W / DATA_WIDTH;
  localparam int BEAT_W         = $clog2(BEATS);
  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP,
    S_HOLD
  } state_e;

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [ADDRESS_WIDTH-1:0]   miss_base_q, miss_base_d;
  logic [ADDRESS_WIDTH-1:0]   evict_base_q, evict_base_d;
  logic [LINE_W-1:0]          evict_line_q, evict_line_d;
  logic [LINE_W-1:0]          fill_buf_q, fill_buf_d;
  logic                       last_beat;
  logic [ADDRESS_WIDTH-1:0]   beat_offset;

`ifdef SA_REFILL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0]          wdog_q, wdog_d;
  logic                       err_q, err_d;
`endif

  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_offset = ADDRESS_WIDTH'(beat_q) * ADDRESS_WIDTH'(BYTES_PER_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
      evict_line_q <= '0;
      fill_buf_q   <= '0;
`ifdef SA_REFILL_TIMEOUT_EN
      wdog_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_base_q  <= miss_base_d;
      evict_base_q <= evict_base_d;
      evict_line_q <= evict_line_d;
      fill_buf_q   <= fill_buf_d;
`ifdef SA_REFILL_TIMEOUT_EN
      wdog_q       <= wdog_d;
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_base_d  = miss_base_q;
    evict_base_d = evict_base_q;
    evict_line_d = evict_line_q;
    fill_buf_d   = fill_buf_q;
`ifdef SA_REFILL_TIMEOUT_EN
    wdog_d       = wdog_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_cache_miss) begin
          miss_base_d  = {i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          evict_base_d = {i_evict_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          evict_line_d = i_evict_line;
          beat_d       = '0;
          state_d      = i_evict ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (i_mem_ack) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        if (i_mem_ack) begin
          fill_buf_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = i_mem_rdata;
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RESP: state_d = S_HOLD;
      // a miss flag still high here belongs to the refill just delivered
      S_HOLD: begin
        if (!i_cache_miss) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SA_REFILL_TIMEOUT_EN
    if (state_q == S_IDLE && i_cache_miss) begin
      wdog_d = '0;
      err_d  = 1'b0;
    end else if (state_q == S_WB || state_q == S_FILL) begin
      if (i_mem_ack) begin
        wdog_d = '0;
      end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        // release the cache with whatever the buffer holds
        wdog_d  = '0;
        err_d   = 1'b1;
        beat_d  = '0;
        state_d = S_RESP;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  assign o_mem_req    = (state_q == S_WB) || (state_q == S_FILL);
  assign o_mem_we     = (state_q == S_WB);
  assign o_mem_addr   = (state_q == S_WB)   ? evict_base_q + beat_offset :
                        (state_q == S_FILL) ? miss_base_q + beat_offset : '0;
  assign o_mem_wdata  = (state_q == S_WB) ? evict_line_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_fill_valid = (state_q == S_RESP);
  assign o_fill_line  = fill_buf_q;
  assign o_busy       = (state_q != S_IDLE);

`ifdef SA_REFILL_TIMEOUT_EN
  assign o_err = err_q;
`else
  // constant 0; the timeout parameter is kept so both builds share one interface
  assign o_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/sa_cache_refill_ctrl.md
# sa_cache_refill_ctrl

Miss-handling sequencer between the 4-way set-associative cache and the word-wide main-memory bus. When the cache raises a miss, it writes back the dirty victim line if one is flagged, then fetches the missing line beat by beat. It assembles the line into a buffer and presents it to the cache with a single-cycle response pulse. It is the only master on the memory bus and is the block that drives the cache's memory-response and memory-line inputs.

## Interface
- LINE_SIZE_BYTES, 64, cache line size; BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH (16 at defaults)
- DATA_WIDTH, 32, memory bus word width
- ADDRESS_WIDTH, 32, byte address width
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES); low bits cleared to form the line base
- TIMEOUT_CYCLES, 255, per-beat ack watchdog limit (used only with the macro)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- i_cache_miss  in  1  level miss flag from the cache
- i_miss_addr  in  ADDRESS_WIDTH  byte address of the missing access
- i_evict  in  1  victim line is valid and dirty and must be written back
- i_evict_line  in  LINE_SIZE_BYTES*8  victim line data
- i_evict_addr  in  ADDRESS_WIDTH  victim line address
- o_fill_line  out  LINE_SIZE_BYTES*8  assembled refill line; connects to the cache memory-line input
- o_fill_valid  out  1  one-cycle refill strobe; connects to the cache memory-response input
- o_mem_req  out  1  memory beat request
- o_mem_we  out  1  1 = write beat, 0 = read beat
- o_mem_addr  out  ADDRESS_WIDTH  word-aligned beat address
- o_mem_wdata  out  DATA_WIDTH  write beat data
- i_mem_ack  in  1  beat accepted (write) or read data valid
- i_mem_rdata  in  DATA_WIDTH  read beat data, valid only with i_mem_ack
- o_busy  out  1  high in every state except IDLE
- o_err  out  1  sticky timeout flag; tied to 0 without the macro

## Operation
- States: IDLE, WB, FILL, RESP, HOLD.
- **IDLE**
  - When i_cache_miss=1, capture into registers: line base of i_miss_addr (low OFFSET_BITS zeroed), i_evict, i_evict_line, and line base of i_evict_addr.
  - Clear the beat counter and o_err.
  - Next state is WB if i_evict=1, else FILL.
- **WB**
  - o_mem_req=1, o_mem_we=1.
  - o_mem_addr = evict base + beat*(DATA_WIDTH/8).
  - o_mem_wdata = captured line[beat*DATA_WIDTH +: DATA_WIDTH].
  - On i_mem_ack, increment the beat counter. After the ack for beat BEATS-1, clear the counter and go to FILL.
- **FILL**
  - o_mem_req=1, o_mem_we=0, address = miss base + beat*(DATA_WIDTH/8).
  - On i_mem_ack, write i_mem_rdata into buffer[beat*DATA_WIDTH +: DATA_WIDTH].
  - After the ack for the last beat, go to RESP.
- **RESP**
  - o_fill_valid=1 for exactly one cycle; o_fill_line = buffer.
  - Next state is HOLD.
- **HOLD**
  - Wait until i_cache_miss=0, then go to IDLE. This prevents a second refill while the cache is still clearing its miss flag.
- Beat counter width is $clog2(BEATS); it resets to 0 on every phase change. Address arithmetic is modulo 2^ADDRESS_WIDTH.
- i_mem_ack is ignored while o_mem_req=0 (IDLE, RESP, HOLD).
- o_fill_line holds its value after RESP until the next FILL overwrites it.
- Changes on i_evict, i_evict_line, i_miss_addr or i_evict_addr after capture have no effect.

## Timing
- Reset values:
  - state IDLE, beat counter 0, buffer all-zero.
  - o_fill_valid=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - o_busy=0, o_err=0.
- Reset asserted mid-operation aborts the transaction immediately: o_mem_req drops asynchronously and no o_fill_valid is produced.
- Outputs are registered or decoded from registered state only; there is no combinational path from i_mem_ack to o_mem_req.
- o_mem_req rises the cycle after the miss is captured.
- o_mem_req stays high across beats. Address and data advance on the edge that samples i_mem_ack.
- A zero-wait memory (ack tied high) sustains one beat per cycle.
- Latency from the IDLE edge that captures i_cache_miss to the o_fill_valid pulse, zero-wait memory:
  - clean miss: BEATS+1 cycles (17 at defaults)
  - dirty miss: 2*BEATS+1 cycles (33 at defaults)
- An i_cache_miss that is still high in HOLD is not a new miss. A new miss needs at least one cycle with i_cache_miss=0.

## Configuration
- Macro SA_REFILL_TIMEOUT_EN.
- **Defined**
  - A watchdog counts consecutive WB/FILL cycles without i_mem_ack and resets on each ack.
  - When the count reaches TIMEOUT_CYCLES, o_err sets (sticky until the next IDLE capture).
  - o_mem_req drops and the state goes to RESP. o_fill_valid still pulses so the cache is released; the buffer content is undefined.
- **Undefined**
  - No watchdog logic; o_err is constant 0.
  - The controller waits indefinitely for i_mem_ack.

## Test plan
- **Clean miss, zero-wait memory:** i_miss_addr=0x0000_1234, i_evict=0, read word k = 0xA000_0000+k.
  - Required: 16 reads at 0x1200..0x123C.
  - o_fill_valid pulses 17 cycles after capture, with o_fill_line[31:0]=0xA000_0000 and [511:480]=0xA000_000F.
- **Dirty miss:** i_evict=1, i_evict_addr=0x0000_4040, line word k = k.
  - Required: 16 writes at 0x4040..0x407C with wdata 0..15.
  - Then 16 reads at the miss base; o_fill_valid at cycle 33.
- **Wait-stated memory:** ack only every 3rd cycle.
  - Required: address and wdata hold stable between acks; correct line assembled; no extra beats issued.
- **Miss held high after the response:** i_cache_miss stays 1 for 5 cycles after o_fill_valid.
  - Required: the controller stays in HOLD, issues no new o_mem_req, and o_busy=1 until the flag drops.
- **Reset mid-FILL:** rst at beat 7.
  - Required: all outputs reach reset values asynchronously, and no o_fill_valid is produced.
  - A subsequent miss completes normally.
- **Timeout, SA_REFILL_TIMEOUT_EN defined:** TIMEOUT_CYCLES=8, ack never asserted.
  - Required: o_mem_req drops after 8 cycles, o_err=1, and one o_fill_valid pulse.
  - o_err clears on the next miss capture.
